// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto one 8-bit synchronous RAM port, one byte per cycle, little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    output logic              if_stall_req,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [2:0]  req_len;
    logic [31:0] wdata;
    logic [31:0] buffer;
    logic [31:0] assembled;
    logic [7:0]  next_wbyte;

    assign if_stall_req  = if_req & ~if_done;
    assign mem_stall_req = mem_req & ~mem_done;

    always_comb begin
        req_len = 3'd4;
        case (mem_size)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // Byte arriving now belongs to the address issued one cycle earlier (cnt-1).
    always_comb begin
        assembled = buffer;
        case (cnt)
            3'd1:    assembled[7:0]   = ram_rdata;
            3'd2:    assembled[15:8]  = ram_rdata;
            3'd3:    assembled[23:16] = ram_rdata;
            default: assembled[31:24] = ram_rdata;
        endcase
    end

    always_comb begin
        next_wbyte = wdata[31:24];
        case (cnt[1:0])
            2'd0:    next_wbyte = wdata[15:8];
            2'd1:    next_wbyte = wdata[23:16];
            default: next_wbyte = wdata[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            wdata     <= 32'd0;
            buffer    <= 32'd0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    // A request still held during its own done cycle must not restart.
                    if (!if_done && !mem_done) begin
                        if (mem_req) begin
                            state    <= mem_we ? MEM_WR : MEM_RD;
                            ram_addr <= mem_addr;
                            len      <= req_len;
                            wdata    <= mem_wdata;
                            cnt      <= 3'd0;
                            buffer   <= 32'd0;
                            ram_we   <= mem_we;
                            if (mem_we) begin
                                ram_wdata <= mem_wdata[7:0];
                            end
                        end else if (if_req && !if_flush) begin
                            state    <= IF_RD;
                            ram_addr <= if_addr;
                            len      <= 3'd4;
                            cnt      <= 3'd0;
                            buffer   <= 32'd0;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && if_flush) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0) begin
                            buffer <= assembled;
                        end
                        if (cnt == len) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                            if (state == IF_RD) begin
                                if_done <= 1'b1;
                                if_data <= assembled;
                            end else begin
                                mem_done  <= 1'b1;
                                mem_rdata <= assembled;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt < len - 3'd1) begin
                                ram_addr <= ram_addr + ADDR_ONE;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt == len - 3'd1) begin
                        ram_we   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= IDLE;
                        cnt      <= 3'd0;
                    end else begin
                        cnt       <= cnt + 3'd1;
                        ram_addr  <= ram_addr + ADDR_ONE;
                        ram_wdata <= next_wbyte;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl: a byte-array reference memory predicts every
// completion (data and cycle); a separate monitor checks each done pulse.
module tb_mem_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_flush = 1'b0;
    logic              if_done;
    logic [31:0]       if_data;
    logic              if_stall_req;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_size = 2'b00;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              mem_stall_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = 8'd0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data), .if_stall_req(if_stall_req),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .mem_stall_req(mem_stall_req),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // RAM model (4 KiB aliased window) and independent reference memory.
    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];
    logic       ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
            ram_loaded <= 1'b1;
        end else begin
            ram_rdata <= ram[ram_addr[11:0]];
            if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_rdata = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got nothing, expected completion (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] refRead(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            r[8*i +: 8] = ref_mem[a[11:0]];
        end
        return r;
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    task automatic handleDone(input bit is_fetch, input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got done (fetch=%0d) data 0x%08h, expected none (cycle %0d)",
                     is_fetch, data, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("done_port", 32'(is_fetch), 32'(e.is_fetch));
            checkOutput(is_fetch ? "if_data" : "mem_rdata", data, e.data);
            checkOutput("done_cycle", 32'(cyc), 32'(e.cycle));
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (if_done === 1'b1) handleDone(1'b1, if_data);
            if (mem_done === 1'b1) handleDone(1'b0, mem_rdata);
        end
    end

    task automatic applyStimulus(input bit is_fetch, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          issue;
        int          off;
        bit          seen;
        bit          done;
        bit          stall;
        bit          is_store;
        logic [31:0] a;
        logic [31:0] sh;
        exp_t        e;
        n = is_fetch ? 4 : sizeBytes(size);
        is_store = !is_fetch && we;
        @(posedge clk); #1;
        issue = cyc;
        if (is_fetch) begin
            if_req = 1'b1;
            if_addr = addr;
        end else begin
            mem_req = 1'b1;
            mem_we = we;
            mem_size = size;
            mem_addr = addr;
            mem_wdata = wdata;
        end
        e.is_fetch = is_fetch;
        if (is_store) begin
            for (int i = 0; i < n; i++) begin
                a = addr + i;
                ref_mem[a[11:0]] = wdata[8*i +: 8];
            end
            e.data = last_rdata;
            e.cycle = issue + n + 1;
        end else begin
            e.data = refRead(addr, n);
            e.cycle = issue + n + 2;
            if (!is_fetch) last_rdata = e.data;
        end
        exp_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            off = cyc - issue;
            if (off == 1) begin
                if (is_fetch) if_addr = $urandom;
                else begin
                    mem_addr = $urandom;
                    mem_wdata = $urandom;
                    mem_size = 2'($urandom);
                end
            end
            done = is_fetch ? (if_done === 1'b1) : (mem_done === 1'b1);
            stall = is_fetch ? (if_stall_req === 1'b1) : (mem_stall_req === 1'b1);
            checkOutput("stall_req", 32'(stall), 32'(!done));
            if (off >= 1 && off <= n) begin
                checkOutput("ram_addr", ram_addr, addr + off - 1);
                checkOutput("ram_we", 32'(ram_we), 32'(is_store));
                if (is_store) begin
                    sh = wdata >> (8 * (off - 1));
                    checkOutput("ram_wdata", 32'(ram_wdata), 32'(sh[7:0]));
                end
            end
            if (done) seen = 1'b1;
        end
        if (!seen) failNow("done_timeout");
        @(posedge clk); #1;
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic simultaneousTest(input logic [31:0] faddr, input logic [31:0] maddr);
        int   issue;
        bit   seen;
        exp_t e;
        @(posedge clk); #1;
        issue = cyc;
        if_req = 1'b1;
        if_addr = faddr;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_size = 2'b10;
        mem_addr = maddr;
        e.is_fetch = 1'b0;
        e.data = refRead(maddr, 4);
        e.cycle = issue + 6;
        last_rdata = e.data;
        exp_q.push_back(e);
        e.is_fetch = 1'b1;
        e.data = refRead(faddr, 4);
        e.cycle = issue + 13;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1) seen = 1'b1;
        end
        if (!seen) failNow("sim_mem_timeout");
        @(posedge clk); #1;
        mem_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (if_done === 1'b1) seen = 1'b1;
        end
        if (!seen) failNow("sim_if_timeout");
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic flushTest(input logic [31:0] faddr);
        @(posedge clk); #1;
        if_req = 1'b1;
        if_addr = faddr;
        repeat (3) begin
            @(posedge clk); #1;
        end
        if_flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        if_flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("post_flush_ram_we", 32'(ram_we), 32'd0);
        end
    endtask

    task automatic resetMidStore(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        @(posedge clk); #1;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_size = 2'b10;
        mem_addr = addr;
        mem_wdata = wdata;
        for (int i = 0; i < 2; i++) begin
            a = addr + i;
            ref_mem[a[11:0]] = wdata[8*i +: 8];
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_mem_done", 32'(mem_done), 32'd0);
        mem_req = 1'b0;
        last_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_ram_addr", ram_addr, 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        checkOutput("rst_if_data", if_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        int          kind;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        ref_mem[12'h100] = 8'h11;
        ref_mem[12'h101] = 8'h22;
        ref_mem[12'h102] = 8'h33;
        ref_mem[12'h103] = 8'h44;
        ref_mem[12'h007] = 8'h80;

        #2 rst = 1'b0;
        #1;
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_ram_addr", ram_addr, 32'd0);
        checkOutput("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        checkOutput("reset_if_done", 32'(if_done), 32'd0);
        checkOutput("reset_mem_done", 32'(mem_done), 32'd0);
        checkOutput("reset_if_data", if_data, 32'd0);
        checkOutput("reset_mem_rdata", mem_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] directed: fetch, store half, load byte");
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h20, 32'hAABBCCDD);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h7, 32'h0);

        $display("[TB] directed: simultaneous requests, flush, mid-store reset");
        simultaneousTest(32'h100, 32'h20);
        flushTest(32'h100);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h1C, 32'h0);
        resetMidStore(32'h40, 32'h5566_7788);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h40, 32'h0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
            else addr = $urandom_range(0, 63);
            applyStimulus(kind == 0, kind == 2, 2'($urandom_range(0, 3)), addr, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4096; i++) begin
            if (i < 12'h200 || i >= 12'hF00) checkOutput("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the single 8-bit synchronous RAM port. Arbitrates instruction-fetch and load/store requests, sequences multi-byte accesses one byte per cycle, assembles and splits little-endian words, and raises the per-stage stall requests consumed by the stall controller. It also returns completion pulses with read data.

## Interface
Parameters:
- ADDR_W, 32, address width for all address ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low; 0 forces reset state immediately
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_flush  in  1  cancels any in-flight or pending fetch (branch taken)
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word
- if_stall_req  out  1  if_req & ~if_done (combinational)
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  32  store data; low n bytes used
- mem_done  out  1  one-cycle pulse; mem_rdata valid for loads
- mem_rdata  out  32  zero-extended little-endian load data
- mem_stall_req  out  1  mem_req & ~mem_done (combinational)
- ram_addr  out  ADDR_W  RAM byte address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte; valid one cycle after ram_addr presented

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt[2:0], length n (1, 2 or 4), 32-bit assembly buffer.
- IDLE: mem_req has priority over if_req. Accept mem_req -> MEM_WR if mem_we else MEM_RD. Otherwise accept if_req & ~if_flush -> IF_RD (n=4). Request fields latched on acceptance; later input changes ignored.
- Reads: ram_addr = base + cnt for cnt 0..n-1 on successive cycles; byte k captured into buffer bits [8k+7:8k] one cycle after its address. After final capture, pulse done with assembled word, return to IDLE.
- Writes: ram_we=1, ram_addr = base + cnt, ram_wdata = wdata[8cnt+7:8cnt] for cnt 0..n-1, one byte per cycle; then pulse mem_done, return to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; no alignment check.
- if_flush in IF_RD: abort to IDLE next edge, no if_done, ram_we stays 0. if_flush has no effect on MEM_* states.
- A pending if_req waits in IDLE until the current data access finishes.
- In IDLE, ram_we=0 and ram_addr holds its last value.
- Data outputs hold their last value between done pulses.

## Timing
- Reset values: state IDLE, cnt 0, ram_we 0, ram_addr 0, ram_wdata 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0, buffer 0. A mid-access reset drops the access with no done pulse.
- Request seen in IDLE in cycle T, with addresses starting at T+1.
- Read of n bytes: done high in cycle T+n+2. A word fetch therefore completes at T+6, and a byte load at T+3.
- Write of n bytes: ram_we high in cycles T+1..T+n; mem_done high at T+n+1.
- done is registered, lasting exactly one cycle. The FSM is in IDLE during the done cycle and may accept a new request in the following cycle. A request still high in the done cycle is not re-accepted that cycle.
- stall_req falls in the done cycle, so the stall controller releases the pipeline on the same edge that the data is consumed.

## Test plan
- Fetch: RAM[0x100..0x103]=11,22,33,44, if_req at 0x100 -> addresses 0x100..0x103 on T+1..T+4, if_done at T+6 with if_data=0x44332211, if_stall_req high T..T+5.
- Store half: mem_size=01, mem_addr=0x20, mem_wdata=0xAABBCCDD -> ram_we at T+1 (0x20, DD) and T+2 (0x21, CC), mem_done at T+3, RAM[0x22] untouched.
- Load byte: RAM[0x7]=0x80 -> mem_rdata=0x00000080 at T+3.
- Simultaneous if_req and mem_req (load word) in IDLE -> data access first, with mem_done at T+6. The fetch is then accepted at T+7 and if_done is seen at T+13.
- if_flush in IF_RD cycle T+3 -> IDLE at T+4, no if_done, later fetch at a new address returns the correct word.
- rst low during a word store after 2 bytes written -> ram_we=0 immediately, no mem_done, remaining bytes unwritten; after release, the FSM is in IDLE.
